// File: rtl/timer_ctrl.sv
// Run/pause/clear sequencer for the MM:SS countdown timer: button FSM,
// 1 Hz decrement strobe, timer re-initialise line and blinking done alarm.
module timer_ctrl #(
  parameter int TICK_DIV    = 100000000,
  parameter int CNT_W       = 27,
  parameter int ALARM_TICKS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_pb,
  input  logic       clr_pb,
  input  logic       stop,
  output logic       tmr_en,
  output logic       tmr_clr,
  output logic [1:0] state,
  output logic       alarm
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int AW = (ALARM_TICKS < 1) ? 1 : $clog2(ALARM_TICKS + 1);
  localparam logic [CNT_W-1:0] PRE_MAX = CNT_W'(TICK_DIV - 1);
  localparam logic [AW-1:0]    ALM_MAX = AW'(ALARM_TICKS);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_pre;
  logic             r_clr;
  logic             r_alarm;
  logic [AW-1:0]    r_acnt;

  logic [1:0]       w_nxt;
  logic             w_tick;
  logic             w_enter_done;

  // clr_pb overrides everything; stop in RUN overrides start_pb
  always_comb begin
    w_nxt = r_state;
    if (clr_pb) begin
      w_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (start_pb) w_nxt = S_RUN;
        S_RUN:   if (stop) w_nxt = S_DONE;
                 else if (start_pb) w_nxt = S_PAUSE;
        S_PAUSE: if (start_pb) w_nxt = S_RUN;
        S_DONE:  if (start_pb) w_nxt = S_IDLE;
        default: w_nxt = S_IDLE;
      endcase
    end
  end

  assign w_tick       = (r_pre == PRE_MAX);
  assign w_enter_done = (w_nxt == S_DONE) && (r_state != S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pre   <= '0;
      r_clr   <= 1'b1;
      r_alarm <= 1'b0;
      r_acnt  <= '0;
    end else begin
      r_state <= w_nxt;
      // acknowledging DONE re-arms the timer just like an abort
      r_clr   <= clr_pb || ((r_state == S_DONE) && start_pb);

      // PAUSE holds the phase so a resumed second is not shortened
      if ((w_nxt == S_IDLE) || w_enter_done)
        r_pre <= '0;
      else if ((r_state == S_RUN) || (r_state == S_DONE))
        r_pre <= w_tick ? '0 : r_pre + 1'b1;

      if (w_nxt != S_DONE) begin
        r_alarm <= 1'b0;
        r_acnt  <= '0;
      end else if (w_enter_done) begin
        r_alarm <= 1'b1;
        r_acnt  <= '0;
      end else if (w_tick && (r_acnt < ALM_MAX)) begin
        r_acnt  <= r_acnt + 1'b1;
        r_alarm <= (r_acnt == ALM_MAX - 1'b1) ? 1'b0 : ~r_alarm;
      end else if (r_acnt >= ALM_MAX) begin
        r_alarm <= 1'b0;
      end
    end
  end

  assign tmr_en  = (r_state == S_RUN) && w_tick && !stop;
  assign tmr_clr = r_clr;
  assign state   = r_state;
  assign alarm   = r_alarm;

endmodule
